// File: rtl/npc_btb.sv
// Next-PC generator: registered fetch PC plus a direct-mapped BTB with
// 2-bit counters, predicting the next packet and last valid slot.
module npc_btb #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter int          FETCH_W   = 2,
  parameter int          BTB_DEPTH = 16,
  parameter int          TAG_W     = 8,
  localparam int         OFS       = 2 + $clog2(FETCH_W),
  localparam int         IDX_W     = $clog2(BTB_DEPTH),
  localparam int         SW        = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [31:0]   flush_target_i,
  input  logic          upd_valid_i,
  input  logic [31:0]   upd_pc_i,
  input  logic [31:0]   upd_target_i,
  input  logic          upd_taken_i,
  output logic [31:0]   pc_o,
  output logic [31:0]   npc_o,
  output logic [SW-1:0] fsc_o,
  output logic [SW-1:0] pred_slot_o,
  output logic          pred_taken_o
);

  logic [31:0]          r_pc;
  logic [BTB_DEPTH-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [BTB_DEPTH];
  logic [SW-1:0]        r_slot [BTB_DEPTH];
  logic [29:0]          r_tgt  [BTB_DEPTH];
  logic [1:0]           r_ctr  [BTB_DEPTH];

  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_uidx;
  logic [TAG_W-1:0]     w_tag;
  logic [TAG_W-1:0]     w_utag;
  logic [SW-1:0]        w_fsc;
  logic [SW-1:0]        w_uslot;
  logic [31-OFS:0]      w_pkt;
  logic [31:0]          w_seq;
  logic                 w_hit;
  logic                 w_uhit;
  logic                 w_ualloc;
  logic [1:0]           w_uctr;
  logic                 w_unused;

  assign w_idx  = r_pc[OFS +: IDX_W];
  assign w_tag  = r_pc[OFS+IDX_W +: TAG_W];
  assign w_uidx = upd_pc_i[OFS +: IDX_W];
  assign w_utag = upd_pc_i[OFS+IDX_W +: TAG_W];

  // Slot fields collapse to a constant zero for single-instruction packets
  generate
    if (FETCH_W > 1) begin : g_slot
      assign w_fsc   = r_pc[OFS-1:2];
      assign w_uslot = upd_pc_i[OFS-1:2];
    end else begin : g_one
      assign w_fsc   = '0;
      assign w_uslot = '0;
    end
  endgenerate

  assign w_unused = ^{upd_pc_i, upd_target_i[1:0],
                      flush_target_i[1:0]};

  assign w_pkt = r_pc[31:OFS] + (32-OFS)'(1);
  assign w_seq = {w_pkt, {OFS{1'b0}}};

  assign w_hit = r_valid[w_idx]
               && (r_tag[w_idx] == w_tag)
               && (r_slot[w_idx] >= w_fsc)
               && r_ctr[w_idx][1];

  always_comb begin
    npc_o        = w_seq;
    pred_slot_o  = SW'(FETCH_W - 1);
    pred_taken_o = 1'b0;
    if (w_hit) begin
      npc_o        = {r_tgt[w_idx], 2'b00};
      pred_slot_o  = r_slot[w_idx];
      pred_taken_o = 1'b1;
    end
  end

  assign pc_o  = r_pc;
  assign fsc_o = w_fsc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (flush_i) begin
      r_pc <= {flush_target_i[31:2], 2'b00};
    end else if (!stall_i) begin
      r_pc <= npc_o;
    end
  end

  assign w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_ualloc = upd_valid_i && upd_taken_i;

  always_comb begin
    w_uctr = 2'b10;
    if (w_uhit) begin
      if (upd_taken_i) begin
        w_uctr = (r_ctr[w_uidx] == 2'b11) ? 2'b11
               : r_ctr[w_uidx] + 2'd1;
      end else begin
        w_uctr = (r_ctr[w_uidx] == 2'b00) ? 2'b00
               : r_ctr[w_uidx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_ualloc) begin
      r_valid[w_uidx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit
  always_ff @(posedge clk) begin
    if (w_ualloc) begin
      r_tag[w_uidx]  <= w_utag;
      r_slot[w_uidx] <= w_uslot;
      r_tgt[w_uidx]  <= upd_target_i[31:2];
    end
    if (upd_valid_i && (upd_taken_i || w_uhit)) begin
      r_ctr[w_uidx] <= w_uctr;
    end
  end

endmodule

// File: tb/tb_npc_btb.sv
// Randomised and directed bench for npc_btb against a
// table-level model of the BTB and fetch PC.
module tb_npc_btb;

  localparam logic [31:0] RPC = 32'h1c00_0000;
  localparam int FW   = 2;
  localparam int DEP  = 16;
  localparam int TW   = 8;
  localparam int OFS  = 3;
  localparam int IDXW = 4;
  localparam int PKT  = 4 * FW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_target_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] npc_o;
  logic [0:0]  fsc_o;
  logic [0:0]  pred_slot_o;
  logic        pred_taken_o;

  npc_btb #(
    .RESET_PC (RPC),
    .FETCH_W  (FW),
    .BTB_DEPTH(DEP),
    .TAG_W    (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .flush_target_i(flush_target_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_target_i  (upd_target_i),
    .upd_taken_i   (upd_taken_i),
    .pc_o          (pc_o),
    .npc_o         (npc_o),
    .fsc_o         (fsc_o),
    .pred_slot_o   (pred_slot_o),
    .pred_taken_o  (pred_taken_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  bit          m_v   [DEP];
  int          m_tag [DEP];
  int          m_slot[DEP];
  logic [31:0] m_tgt [DEP];
  int          m_ctr [DEP];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> OFS) % DEP);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (OFS + IDXW)) % (1 << TW));
  endfunction

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % FW);
  endfunction

  task automatic predict(input logic [31:0] pc, output logic [31:0] npc,
                         output int slot, output bit tk);
    int i;
    i = idx_of(pc);
    if (m_v[i] && m_tag[i] == tag_of(pc) && m_slot[i] >= slot_of(pc)
        && m_ctr[i] >= 2) begin
      npc = m_tgt[i];
      slot = m_slot[i];
      tk = 1'b1;
    end else begin
      npc = (pc & ~32'(PKT - 1)) + 32'(PKT);
      slot = FW - 1;
      tk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    for (int i = 0; i < DEP; i++) m_v[i] = 1'b0;
  endtask

  task automatic check_outs();
    logic [31:0] e_npc;
    int e_slot;
    bit e_tk;
    predict(m_pc, e_npc, e_slot, e_tk);
    chk("pc", pc_o, m_pc);
    chk("npc", npc_o, e_npc);
    chk("fsc", 32'(fsc_o), 32'(slot_of(m_pc)));
    chk("slot", 32'(pred_slot_o), 32'(e_slot));
    chk("taken", 32'(pred_taken_o), 32'(e_tk));
  endtask

  task automatic cyc(input bit st, input bit fl, input logic [31:0] ft,
                     input bit uv, input logic [31:0] up,
                     input logic [31:0] ut, input bit tk);
    logic [31:0] e_npc;
    int e_slot, i;
    bit e_tk, hit;
    stall_i = st;
    flush_i = fl;
    flush_target_i = ft;
    upd_valid_i = uv;
    upd_pc_i = up;
    upd_target_i = ut;
    upd_taken_i = tk;
    #1;
    check_outs();
    predict(m_pc, e_npc, e_slot, e_tk);
    @(posedge clk);
    if (fl) m_pc = ft & ~32'h3;
    else if (!st) m_pc = e_npc;
    if (uv) begin
      i = idx_of(up);
      hit = m_v[i] && m_tag[i] == tag_of(up);
      if (hit) begin
        m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      end else if (tk) begin
        m_v[i] = 1'b1;
        m_tag[i] = tag_of(up);
        m_ctr[i] = 2;
      end
      if (tk) begin
        m_slot[i] = slot_of(up);
        m_tgt[i] = ut & ~32'h3;
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic flush(input logic [31:0] t, input bit st);
    cyc(st, 1, t, 0, '0, '0, 0);
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t,
                     input bit tk, input bit st);
    cyc(st, 0, '0, 1, p, t, tk);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 3) == 0)
      return RPC + 32'($urandom_range(0, 'h7fff));
    return RPC + 32'($urandom_range(0, 'h7f));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("rst_taken", 32'(pred_taken_o), 32'd0);
    chk("rst_slot", 32'(pred_slot_o), 32'd1);
    chk("rst_npc", npc_o, 32'h1c00_0008);

    // sequential fetch
    idle(); chk("t1_pc1", pc_o, 32'h1c00_0008);
    idle(); chk("t1_pc2", pc_o, 32'h1c00_0010);
    idle(); chk("t1_pc3", pc_o, 32'h1c00_0018);

    // stall, then flush beats stall
    cyc(1, 0, '0, 0, '0, '0, 0);
    cyc(1, 0, '0, 0, '0, '0, 0);
    chk("t2_hold", pc_o, 32'h1c00_0018);
    flush(32'h1c00_0106, 1);
    chk("t2_pc", pc_o, 32'h1c00_0104);
    chk("t2_fsc", 32'(fsc_o), 32'd1);
    chk("t2_npc", npc_o, 32'h1c00_0108);

    // taken branch in slot 1
    upd(32'h1c00_0024, 32'h1c00_0100, 1, 0);
    flush(32'h1c00_0020, 0);
    chk("t3_tk", 32'(pred_taken_o), 32'd1);
    chk("t3_slot", 32'(pred_slot_o), 32'd1);
    chk("t3_npc", npc_o, 32'h1c00_0100);
    idle(); chk("t3_pc", pc_o, 32'h1c00_0100);

    // branch moved to slot 0, invisible from fsc 1
    upd(32'h1c00_0020, 32'h1c00_0200, 1, 0);
    flush(32'h1c00_0024, 0);
    chk("t4_miss", 32'(pred_taken_o), 32'd0);
    chk("t4_npc", npc_o, 32'h1c00_0028);
    flush(32'h1c00_0020, 0);
    chk("t4_hit", 32'(pred_taken_o), 32'd1);
    chk("t4_slot", 32'(pred_slot_o), 32'd0);
    chk("t4_tgt", npc_o, 32'h1c00_0200);

    // counter walk while stalled on the looked-up entry
    flush(32'h1c00_0040, 1);
    upd(32'h1c00_0040, 32'h1c00_0300, 1, 1);
    chk("t5_alloc", 32'(pred_taken_o), 32'd1);
    upd(32'h1c00_0040, 32'h1c00_0300, 0, 1);
    chk("t5_weak", 32'(pred_taken_o), 32'd0);
    upd(32'h1c00_0040, 32'h1c00_0300, 1, 1);
    chk("t5_back", 32'(pred_taken_o), 32'd1);
    upd(32'h1c00_0040, 32'h1c00_0300, 1, 1);
    upd(32'h1c00_0040, 32'h1c00_0300, 1, 1);
    upd(32'h1c00_0040, 32'h1c00_0300, 0, 1);
    chk("t5_sat", 32'(pred_taken_o), 32'd1);
    upd(32'h1c00_0040, 32'h1c00_0300, 0, 1);
    chk("t5_off", 32'(pred_taken_o), 32'd0);

    // alias eviction
    upd(32'h1c00_4020, 32'h1c00_0400, 1, 0);
    flush(32'h1c00_0020, 1);
    chk("t6_alias", 32'(pred_taken_o), 32'd0);
    flush(32'h1c00_4020, 1);
    chk("t6_new", npc_o, 32'h1c00_0400);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1 chk("t6_rstpc", pc_o, RPC);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    flush(32'h1c00_0020, 0);
    chk("t6_cleared", 32'(pred_taken_o), 32'd0);

    // sequential wrap at the top of the address space
    flush(32'hffff_fffe, 1);
    chk("wrap_npc", npc_o, 32'h0000_0000);
    idle();
    chk("wrap_pc", pc_o, 32'h0000_0000);

    for (int n = 0; n < 3000; n++) begin
      bit st, fl, uv, tk;
      logic [31:0] up;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 11) == 0);
      uv = ($urandom_range(0, 1) == 1);
      tk = ($urandom_range(0, 2) != 0);
      up = ($urandom_range(0, 1) == 1)
         ? m_pc + 32'($urandom_range(0, 7)) : rnd_pc();
      cyc(st, fl, rnd_pc(), uv, up, rnd_pc(), tk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
